// File: rtl/dino_pkg.sv
// Shared definitions for the dino game pipeline stages.
// Used by the collision controller and the cactus generator.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [9:0] H_VIS       = 10'd640;
  localparam logic [8:0] V_VIS       = 9'd480;
  localparam logic [8:0] CACTUS_ROW0 = 9'd344;

  function automatic logic in_vis(
    input logic [8:0] row,
    input logic [9:0] col
  );
    return (col < H_VIS) && (row < V_VIS);
  endfunction

endpackage

// File: rtl/collision_ctrl_if.sv
// Pixel/scan inputs and game-state outputs of the collision stage.
// master drives the scan side, slave is the controller.
interface collision_ctrl_if;

  logic        START;
  logic        fresh;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        cactus_px;
  logic        dino_px;
  logic        game_status;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        game_over;
  logic        hit;

  modport master (
    output START, fresh, row_addr, col_addr,
    output cactus_px, dino_px,
    input  game_status, speed, score,
    input  game_over, hit
  );

  modport slave (
    input  START, fresh, row_addr, col_addr,
    input  cactus_px, dino_px,
    output game_status, speed, score,
    output game_over, hit
  );

endinterface

// File: rtl/fresh_edge.sv
// Frame boundary detector: one-cycle pulse on the
// falling edge of the frame strobe.
module fresh_edge (
  input  logic clk,
  input  logic rst,
  input  logic fresh_i,
  output logic fe_o
);

  logic fresh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fresh_q <= 1'b0;
    else     fresh_q <= fresh_i;
  end

  assign fe_o = fresh_q & ~fresh_i;

endmodule

// File: rtl/collision_ctrl.sv
// Game control: overlap detection, IDLE/RUN/OVER FSM,
// per-frame score and scroll speed.
module collision_ctrl
  import dino_pkg::*;
#(
  parameter logic [3:0]  SPEED_INIT = 4'd2,
  parameter logic [3:0]  SPEED_MAX  = 4'd12,
  parameter logic [9:0]  SPEED_STEP = 10'd600,
  parameter logic [3:0]  SCORE_DIV  = 4'd6,
  parameter int unsigned PX_LAT     = 1
) (
  input logic             clk,
  input logic             RESET,
  collision_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        hit_q, hit_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  speed_q, speed_d;
  logic [3:0]  div_q, div_d;
  logic [9:0]  frm_q, frm_d;
  logic        run_q, run_d;
  logic        over_q, over_d;
  logic [PX_LAT-1:0] vis_q;

  logic fe;
  logic vis_dly;
  logic ov;
  logic entry;
  logic clean_fe;

  fresh_edge u_fresh_edge (
    .clk     (clk),
    .rst     (RESET),
    .fresh_i (bus.fresh),
    .fe_o    (fe)
  );

  // Visibility follows the address, delayed to line up with the pixels
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vis_q <= '0;
    end else begin
      vis_q[0] <= in_vis(bus.row_addr, bus.col_addr);
      for (int i = 1; i < PX_LAT; i++)
        vis_q[i] <= vis_q[i-1];
    end
  end

  assign vis_dly = vis_q[PX_LAT-1];
  assign ov      = bus.cactus_px & bus.dino_px & vis_dly;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      score_q <= '0;
      speed_q <= SPEED_INIT;
      div_q   <= '0;
      frm_q   <= '0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      speed_q <= speed_d;
      div_q   <= div_d;
      frm_q   <= frm_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  // START outranks a coincident frame edge outside RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, OVER: if (bus.START) state_d = RUN;
      RUN:        if (fe && (hit_q || ov)) state_d = OVER;
      default:    state_d = IDLE;
    endcase
  end

  assign entry    = (state_q != RUN) && bus.START;
  assign clean_fe = (state_q == RUN) && fe && !(hit_q || ov);

  always_comb begin
    run_d   = (state_d == RUN);
    over_d  = (state_d == OVER);
    hit_d   = 1'b0;
    score_d = score_q;
    speed_d = speed_q;
    div_d   = div_q;
    frm_d   = frm_q;
    if (entry) begin
      score_d = '0;
      speed_d = SPEED_INIT;
      div_d   = '0;
      frm_d   = '0;
    end else if (state_q == RUN) begin
      hit_d = fe ? 1'b0 : (hit_q | ov);
      if (clean_fe) begin
        if (div_q == SCORE_DIV - 4'd1) begin
          div_d = '0;
          if (score_q != 16'hFFFF)
            score_d = score_q + 16'd1;
        end else begin
          div_d = div_q + 4'd1;
        end
        if (frm_q == SPEED_STEP - 10'd1) begin
          frm_d = '0;
          if (speed_q < SPEED_MAX)
            speed_d = speed_q + 4'd1;
        end else begin
          frm_d = frm_q + 10'd1;
        end
      end
    end
  end

  assign bus.game_status = run_q;
  assign bus.game_over   = over_q;
  assign bus.hit         = hit_q;
  assign bus.score       = score_q;
  assign bus.speed       = speed_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: per-cycle scoreboard against a
// frame-count model, plus directed scenario checks.
module tb_collision_ctrl;

  logic clk   = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  collision_ctrl_if bus ();
  collision_ctrl_if bus2 ();

  assign bus2.START     = bus.START;
  assign bus2.fresh     = bus.fresh;
  assign bus2.row_addr  = bus.row_addr;
  assign bus2.col_addr  = bus.col_addr;
  assign bus2.cactus_px = bus.cactus_px;
  assign bus2.dino_px   = bus.dino_px;

  collision_ctrl u_dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  collision_ctrl #(.SPEED_STEP(10'd2)) u_dut2 (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus2)
  );

  typedef struct {
    int   st;
    int   frames;
    logic hit;
    logic fq;
    logic vq;
  } mdl_t;

  mdl_t m_q = '{0, 0, 1'b0, 1'b0, 1'b0};
  mdl_t sb[$];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_f(input mdl_t s);
    mdl_t n;
    logic fe, ov;
    n = s;
    if (RESET) begin
      n = '{0, 0, 1'b0, 1'b0, 1'b0};
      return n;
    end
    fe = s.fq && !bus.fresh;
    ov = bus.cactus_px && bus.dino_px && s.vq;
    if (s.st == 1) begin
      if (fe) begin
        if (s.hit || ov) n.st = 2;
        else             n.frames = s.frames + 1;
        n.hit = 1'b0;
      end else begin
        n.hit = s.hit | ov;
      end
    end else if (bus.START) begin
      n.st     = 1;
      n.frames = 0;
      n.hit    = 1'b0;
    end
    n.fq = bus.fresh;
    n.vq = (bus.col_addr < 640) && (bus.row_addr < 480);
    return n;
  endfunction

  function automatic int exp_score(input int f);
    return (f / 6 > 65535) ? 65535 : f / 6;
  endfunction

  function automatic int exp_speed(input int f, input int step);
    return (2 + f / step > 12) ? 12 : 2 + f / step;
  endfunction

  always @(posedge clk) begin : mdl
    mdl_t n;
    n = mdl_f(m_q);
    m_q <= n;
    sb.push_back(n);
  end

  always @(posedge clk) begin : sb_chk
    mdl_t e;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("gs",     bus.game_status, e.st == 1);
      chk("go",     bus.game_over,   e.st == 2);
      chk("hit",    bus.hit,         e.hit);
      chk("score",  bus.score,       exp_score(e.frames));
      chk("speed",  bus.speed,       exp_speed(e.frames, 600));
      chk("gs2",    bus2.game_status, e.st == 1);
      chk("go2",    bus2.game_over,   e.st == 2);
      chk("hit2",   bus2.hit,         e.hit);
      chk("score2", bus2.score,       exp_score(e.frames));
      chk("speed2", bus2.speed,       exp_speed(e.frames, 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fe_pulse();
    bus.fresh = 1'b1;
    cyc();
    bus.fresh = 1'b0;
    cyc();
  endtask

  task automatic overlap(input logic [8:0] r, input logic [9:0] c);
    bus.row_addr  = r;
    bus.col_addr  = c;
    cyc();
    bus.cactus_px = 1'b1;
    bus.dino_px   = 1'b1;
    cyc();
    bus.cactus_px = 1'b0;
    bus.dino_px   = 1'b0;
    bus.row_addr  = '0;
    bus.col_addr  = '0;
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.fresh     = 1'b0;
    bus.row_addr  = '0;
    bus.col_addr  = '0;
    bus.cactus_px = 1'b0;
    bus.dino_px   = 1'b0;
    repeat (3) cyc();
    chk("rst_gs",    bus.game_status, 0);
    chk("rst_go",    bus.game_over,   0);
    chk("rst_hit",   bus.hit,         0);
    chk("rst_score", bus.score,       0);
    chk("rst_speed", bus.speed,       2);
    RESET = 1'b0;
    cyc();

    bus.START = 1'b1;
    cyc();
    bus.START = 1'b0;
    chk("start_gs", bus.game_status, 1);
    repeat (6) fe_pulse();
    chk("score6", bus.score, 1);
    repeat (6) fe_pulse();
    chk("score12", bus.score, 2);
    repeat (7) fe_pulse();
    chk("spd2_f19", bus2.speed, 11);
    fe_pulse();
    chk("spd2_f20", bus2.speed, 12);
    repeat (10) fe_pulse();
    chk("spd2_f30", bus2.speed, 12);
    repeat (569) fe_pulse();
    chk("spd_f599", bus.speed, 2);
    fe_pulse();
    chk("spd_f600",   bus.speed, 3);
    chk("score_f600", bus.score, 100);

    overlap(9'd100, 10'd650);
    chk("hit_col650", bus.hit, 0);
    overlap(9'd500, 10'd100);
    chk("hit_row500", bus.hit, 0);
    fe_pulse();
    chk("run_offvis", bus.game_status, 1);

    overlap(9'd360, 10'd300);
    chk("hit_on", bus.hit, 1);
    fe_pulse();
    chk("over_go",    bus.game_over,   1);
    chk("over_gs",    bus.game_status, 0);
    chk("over_score", bus.score,       100);
    chk("over_hitclr", bus.hit,        0);
    overlap(9'd360, 10'd300);
    chk("hit_in_over", bus.hit, 0);

    bus.fresh = 1'b1;
    cyc();
    bus.fresh = 1'b0;
    bus.START = 1'b1;
    cyc();
    chk("sfe_gs",    bus.game_status, 1);
    chk("sfe_score", bus.score,       0);
    chk("sfe_speed", bus.speed,       2);
    fe_pulse();
    fe_pulse();
    bus.START = 1'b0;
    chk("held_gs",   bus.game_status, 1);
    chk("held_spd2", bus2.speed,      3);

    bus.row_addr  = 9'd360;
    bus.col_addr  = 10'd300;
    bus.fresh     = 1'b1;
    cyc();
    bus.fresh     = 1'b0;
    bus.cactus_px = 1'b1;
    bus.dino_px   = 1'b1;
    cyc();
    bus.cactus_px = 1'b0;
    bus.dino_px   = 1'b0;
    bus.row_addr  = '0;
    bus.col_addr  = '0;
    chk("ovfe_go", bus.game_over, 1);

    bus.START = 1'b1;
    cyc();
    bus.START = 1'b0;
    chk("restart_gs", bus.game_status, 1);

    repeat (3) fe_pulse();
    overlap(9'd360, 10'd300);
    chk("pre_rst_hit", bus.hit, 1);
    bus.fresh = 1'b1;
    RESET = 1'b1;
    #1;
    chk("arst_gs",   bus.game_status, 0);
    chk("arst_hit",  bus.hit,         0);
    chk("arst_spd2", bus2.speed,      2);
    chk("arst_go",   bus.game_over,   0);
    cyc();
    cyc();
    chk("hrst_gs",    bus.game_status, 0);
    chk("hrst_score", bus.score,       0);
    RESET = 1'b0;
    bus.fresh = 1'b0;
    cyc();
    cyc();
    chk("post_gs",    bus.game_status, 0);
    chk("post_speed", bus.speed,       2);
    chk("post_hit",   bus.hit,         0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
